// File: rtl/uart_in_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_in_arbiter
//  Description : Round-robin merge of UART receive FIFOs into one USB transmit
//                FIFO, framing each byte as a header word (UART index) + data.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_in_arbiter #(
    parameter int DATA_BITS  = 8,
    parameter int UART_COUNT = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [UART_COUNT-1:0]           rx_empty,
    output logic [UART_COUNT-1:0]           rx_read,
    input  logic [UART_COUNT*DATA_BITS-1:0] rx_data,
    input  logic                            fifo_full,
    output logic                            fifo_write,
    output logic [DATA_BITS-1:0]            fifo_data,
    output logic                            busy
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_HDR     = 2'd1;
    localparam logic [1:0] c_HDR_GAP = 2'd2;
    localparam logic [1:0] c_DATA    = 2'd3;

    localparam logic [3:0]            c_LAST_IDX = 4'(UART_COUNT - 1);
    localparam logic [UART_COUNT-1:0] c_ONE      = UART_COUNT'(1);

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic [3:0]            r_grant;
    logic [DATA_BITS-1:0]  r_latch;
    logic [3:0]            r_last_grant;

    logic                  w_found;
    logic [3:0]            w_pick;
    logic [3:0]            w_idx;
    logic [DATA_BITS-1:0]  w_pick_data;

    logic [UART_COUNT-1:0] w_rx_read_nxt;
    logic                  w_write_nxt;
    logic [DATA_BITS-1:0]  w_data_nxt;

    // Walk the ring starting after the last served UART; the wrap is an
    // explicit compare so non-power-of-two counts go straight back to 0.
    always_comb begin
        w_found     = 1'b0;
        w_pick      = '0;
        w_pick_data = '0;
        w_idx       = r_last_grant;
        for (int k = 0; k < UART_COUNT; k++) begin
            w_idx = (w_idx == c_LAST_IDX) ? 4'd0 : w_idx + 4'd1;
            for (int i = 0; i < UART_COUNT; i++) begin
                if (!w_found && (w_idx == 4'(i)) && !rx_empty[i]) begin
                    w_found     = 1'b1;
                    w_pick      = w_idx;
                    w_pick_data = rx_data[i*DATA_BITS +: DATA_BITS];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= c_IDLE;
            r_grant      <= '0;
            r_latch      <= '0;
            r_last_grant <= c_LAST_IDX;
        end else begin
            r_state <= w_next_state;
            if ((r_state == c_IDLE) && w_found) begin
                r_grant <= w_pick;
                r_latch <= w_pick_data;
            end
            if ((r_state == c_DATA) && !fifo_full) begin
                r_last_grant <= r_grant;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:    if (w_found)    w_next_state = c_HDR;
            c_HDR:     if (!fifo_full) w_next_state = c_HDR_GAP;
            // One spare cycle lets fifo_full catch up with the header write.
            c_HDR_GAP:                 w_next_state = c_DATA;
            c_DATA:    if (!fifo_full) w_next_state = c_IDLE;
            default:                   w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        w_rx_read_nxt = '0;
        w_write_nxt   = 1'b0;
        w_data_nxt    = fifo_data;
        case (r_state)
            c_IDLE: begin
                if (w_found) w_rx_read_nxt = c_ONE << w_pick;
            end
            c_HDR: begin
                if (!fifo_full) begin
                    w_write_nxt = 1'b1;
                    w_data_nxt  = DATA_BITS'(r_grant);
                end
            end
            c_DATA: begin
                if (!fifo_full) begin
                    w_write_nxt = 1'b1;
                    w_data_nxt  = r_latch;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_read    <= '0;
            fifo_write <= 1'b0;
            fifo_data  <= '0;
            busy       <= 1'b0;
        end else begin
            rx_read    <= w_rx_read_nxt;
            fifo_write <= w_write_nxt;
            fifo_data  <= w_data_nxt;
            busy       <= (w_next_state != c_IDLE);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_in_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_in_arbiter
//  Description : Self-checking bench for uart_in_arbiter (4- and 3-UART builds).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_in_arbiter;

    localparam int DW  = 8;
    localparam int NU  = 4;
    localparam int NU3 = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic [NU-1:0]    rx_empty, rx_read;
    logic [NU*DW-1:0] rx_data;
    logic             fifo_full, fifo_write, busy;
    logic [DW-1:0]    fifo_data;

    logic [NU3-1:0]    rx_empty3, rx_read3;
    logic [NU3*DW-1:0] rx_data3;
    logic              fifo_full3, fifo_write3, busy3;
    logic [DW-1:0]     fifo_data3;

    always #5 clk = ~clk;

    uart_in_arbiter #(.DATA_BITS(DW), .UART_COUNT(NU)) dut (
        .clk(clk), .reset(reset), .rx_empty(rx_empty), .rx_read(rx_read),
        .rx_data(rx_data), .fifo_full(fifo_full), .fifo_write(fifo_write),
        .fifo_data(fifo_data), .busy(busy)
    );

    uart_in_arbiter #(.DATA_BITS(DW), .UART_COUNT(NU3)) dut3 (
        .clk(clk), .reset(reset), .rx_empty(rx_empty3), .rx_read(rx_read3),
        .rx_data(rx_data3), .fifo_full(fifo_full3), .fifo_write(fifo_write3),
        .fifo_data(fifo_data3), .busy(busy3)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int nreads   = 0;

    logic [7:0] q[NU][$];
    logic [7:0] q3[NU3][$];
    logic [7:0] pend[$];
    int         m_last, m_cur, m_nb, m_pop_i, m_pop_at;
    logic [NU-1:0] exp_read, prev_read;
    logic       exp_write, exp_busy, exp_hdr, prev_write, prev_full, saw_hdr;
    logic [7:0] exp_data;
    logic [7:0] wlog[$];
    int         wcyc[$];
    logic [7:0] log3[$];

    logic [7:0] rr_exp [16] = '{8'h00, 8'h10, 8'h01, 8'h11, 8'h02, 8'h12, 8'h03, 8'h13,
                                8'h00, 8'h20, 8'h01, 8'h21, 8'h02, 8'h22, 8'h03, 8'h23};
    logic [7:0] wrap_exp [8] = '{8'h01, 8'h31, 8'h02, 8'h32, 8'h00, 8'h30, 8'h02, 8'h42};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [31:0] get_w(input int k);
        if (k < wlog.size()) return 32'(wlog[k]);
        return 32'hDEAD;
    endfunction

    function automatic logic [31:0] get3(input int k);
        if (k < log3.size()) return 32'(log3[k]);
        return 32'hDEAD;
    endfunction

    function automatic logic any_queued();
        logic r;
        r = 1'b0;
        for (int i = 0; i < NU; i++) if (q[i].size() != 0) r = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        pend.delete();
        m_last = NU - 1; m_cur = 0; m_nb = 0; m_pop_i = 0; m_pop_at = -1;
        exp_read = '0; exp_write = 1'b0; exp_busy = 1'b0; exp_hdr = 1'b0; exp_data = '0;
        prev_read = '0; prev_write = 1'b0; prev_full = 1'b0;
    endtask

    task automatic drive();
        for (int i = 0; i < NU; i++) begin
            rx_empty[i]         = (q[i].size() == 0);
            rx_data[i*DW +: DW] = (q[i].size() != 0) ? q[i][0] : 8'h00;
        end
        for (int i = 0; i < NU3; i++) begin
            rx_empty3[i]         = (q3[i].size() == 0);
            rx_data3[i*DW +: DW] = (q3[i].size() != 0) ? q3[i][0] : 8'h00;
        end
    endtask

    // Transaction view: a grant queues {header, byte}; each word goes out on the
    // cycle after a non-full decision, and words of one grant are >= 2 cycles apart.
    task automatic model_update(input logic full_v);
        logic found;
        exp_read = '0; exp_write = 1'b0; exp_hdr = 1'b0;
        found = 1'b0;
        if (pend.size() == 0) begin
            for (int k = 1; k <= NU; k++) begin
                int i;
                i = (m_last + k) % NU;
                if (!found && q[i].size() != 0) begin
                    found    = 1'b1;
                    exp_read = NU'(1) << i;
                    pend.push_back(8'(i));
                    pend.push_back(q[i][0]);
                    m_cur = i; m_nb = cyc + 1; m_pop_i = i; m_pop_at = cyc + 2;
                end
            end
        end else if (cyc >= m_nb && !full_v) begin
            exp_write = 1'b1;
            exp_data  = pend.pop_front();
            if (pend.size() == 0) m_last = m_cur;
            else begin
                m_nb    = cyc + 2;
                exp_hdr = 1'b1;
            end
        end
        exp_busy = (pend.size() != 0);
    endtask

    task automatic step(input logic full_v, input logic rst_v);
        @(negedge clk);
        cyc++;
        chk("rx_read", 32'(rx_read), 32'(exp_read));
        chk("fifo_write", 32'(fifo_write), 32'(exp_write));
        chk("fifo_data", 32'(fifo_data), 32'(exp_data));
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("read_onehot", 32'($countones(rx_read) <= 1), 32'd1);
        chk("read_pulse", 32'((|rx_read) && (|prev_read)), 32'd0);
        chk("write_pulse", 32'(fifo_write && prev_write), 32'd0);
        chk("write_when_full", 32'(fifo_write && prev_full), 32'd0);
        saw_hdr = exp_write && exp_hdr;
        if (fifo_write) begin
            wlog.push_back(fifo_data);
            wcyc.push_back(cyc);
        end
        if (|rx_read) nreads++;
        prev_write = fifo_write;
        prev_read  = rx_read;
        if (fifo_write3) log3.push_back(fifo_data3);
        for (int i = 0; i < NU3; i++)
            if (rx_read3[i] && q3[i].size() != 0) void'(q3[i].pop_front());
        if (m_pop_at == cyc && q[m_pop_i].size() != 0) void'(q[m_pop_i].pop_front());
        reset      = rst_v;
        fifo_full  = full_v;
        fifo_full3 = 1'b0;
        drive();
        if (rst_v) model_reset();
        else       model_update(full_v);
        prev_full = full_v;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((pend.size() != 0 || any_queued()) && t < 300) begin
            step(1'b0, 1'b0);
            t++;
        end
        chk("drain_timeout", 32'(t < 300), 32'd1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; fifo_full = 1'b0; fifo_full3 = 1'b0; saw_hdr = 1'b0;
        model_reset();
        drive();
        step(1'b0, 1'b1);
        chk("rst_rx_read", 32'(rx_read), 32'd0);
        chk("rst_write", 32'(fifo_write), 32'd0);
        chk("rst_data", 32'(fifo_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);

        // Round robin from UART 0, two bytes per FIFO
        for (int i = 0; i < NU; i++) begin
            q[i].push_back(8'h10 + 8'(i));
            q[i].push_back(8'h20 + 8'(i));
        end
        wlog.delete(); wcyc.delete();
        for (int t = 0; t < 80 && wlog.size() < 16; t++) step(1'b0, 1'b0);
        chk("rr_count", 32'(wlog.size()), 32'd16);
        for (int k = 0; k < 16; k++) chk("rr_word", get_w(k), 32'(rr_exp[k]));
        for (int k = 1; k < 16 && k < wcyc.size(); k++)
            chk("rr_spacing", 32'(wcyc[k] - wcyc[k-1]), 32'd2);
        drain();

        // Single byte on UART 2
        q[2].push_back(8'hA5);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("sb_read", 32'(rx_read), 32'b0100);
        chk("sb_busy1", 32'(busy), 32'd1);
        step(1'b0, 1'b0);
        chk("sb_hdr_write", 32'(fifo_write), 32'd1);
        chk("sb_hdr", 32'(fifo_data), 32'h02);
        chk("sb_busy2", 32'(busy), 32'd1);
        step(1'b0, 1'b0);
        chk("sb_gap_write", 32'(fifo_write), 32'd0);
        chk("sb_busy3", 32'(busy), 32'd1);
        step(1'b0, 1'b0);
        chk("sb_data_write", 32'(fifo_write), 32'd1);
        chk("sb_data", 32'(fifo_data), 32'hA5);
        chk("sb_busy4", 32'(busy), 32'd0);
        drain();

        // Backpressure in HDR then in DATA
        q[1].push_back(8'h5C);
        wlog.delete(); nreads = 0;
        step(1'b0, 1'b0);
        repeat (10) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        repeat (5) step(1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b0);
        chk("bp_reads", 32'(nreads), 32'd1);
        chk("bp_words", 32'(wlog.size()), 32'd2);
        chk("bp_hdr", get_w(0), 32'h01);
        chk("bp_data", get_w(1), 32'h5C);
        drain();

        // Three-UART build: wrap from 2 back to 0
        q3[1].push_back(8'h31);
        for (int t = 0; t < 40 && log3.size() < 2; t++) step(1'b0, 1'b0);
        q3[2].push_back(8'h32); q3[2].push_back(8'h42); q3[0].push_back(8'h30);
        for (int t = 0; t < 80 && log3.size() < 8; t++) step(1'b0, 1'b0);
        chk("wrap_count", 32'(log3.size()), 32'd8);
        for (int k = 0; k < 8; k++) chk("wrap_word", get3(k), 32'(wrap_exp[k]));

        // Reset while the grant to UART 2 sits in the header gap
        q[1].push_back(8'h61);
        drain();
        q[2].push_back(8'h62);
        saw_hdr = 1'b0;
        for (int t = 0; t < 20 && !saw_hdr; t++) step(1'b0, 1'b0);
        chk("rst_reach_gap", 32'(saw_hdr), 32'd1);
        reset = 1'b1;
        #1;
        chk("arst_rx_read", 32'(rx_read), 32'd0);
        chk("arst_write", 32'(fifo_write), 32'd0);
        chk("arst_data", 32'(fifo_data), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        model_reset();
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        q[0].push_back(8'h70); q[2].push_back(8'h72);
        wlog.delete();
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("arst_priority", 32'(rx_read), 32'b0001);
        drain();
        chk("arst_words", 32'(wlog.size()), 32'd4);
        chk("arst_hdr0", get_w(0), 32'h00);
        chk("arst_data0", get_w(1), 32'h70);
        chk("arst_hdr1", get_w(2), 32'h02);
        chk("arst_data1", get_w(3), 32'h72);

        // Random traffic and backpressure
        for (int t = 0; t < 3000; t++) begin
            for (int i = 0; i < NU; i++)
                if ($urandom_range(0, 9) == 0 && q[i].size() < 4) q[i].push_back(8'($urandom));
            step($urandom_range(0, 3) == 0, 1'b0);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
